// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock-enable divider: per-channel period/high time,
// one-cycle tick at each period start, settings staged in a shadow and applied at boundaries.
module prog_clk_divider #(
  parameter int WIDTH      = 32,
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_HIGH   = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [WIDTH-1:0] load_period,
  input  logic [WIDTH-1:0] load_high,
  output logic [N_CH-1:0]  div_clk,
  output logic [N_CH-1:0]  tick
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_HIGH);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  typedef enum logic {
    ST_STOP,
    ST_RUN
  } ch_state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_t        state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] period_reg, period_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic [WIDTH-1:0] shadow_period_reg, shadow_period_next;
    logic [WIDTH-1:0] shadow_high_reg, shadow_high_next;
    logic             pending_reg, pending_next;
    logic             div_reg, div_next;
    logic             tick_reg, tick_next;

    logic             wr_hit;
    logic             apply;
    logic             idle;
    logic             wrap;
    logic [WIDTH-1:0] eff_high;
    logic [WIDTH-1:0] cnt_inc;

    // Out-of-range load_ch values never match any channel index, so they are dropped.
    assign wr_hit   = load && (load_ch == CH_W'(gi));
    assign eff_high = pending_reg ? shadow_high_reg : high_reg;
    assign cnt_inc  = cnt_reg + ONE;
    assign idle     = (period_reg < TWO);
    assign wrap     = (cnt_reg == period_reg - ONE);

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      div_next   = div_reg;
      tick_next  = 1'b0;
      apply      = 1'b0;

      if (!en) begin
        state_next = ST_STOP;
        cnt_next   = '0;
        div_next   = 1'b0;
        apply      = pending_reg;
      end else begin
        case (state_reg)
          ST_STOP: begin
            state_next = ST_RUN;
            apply      = pending_reg;
            cnt_next   = '0;
            tick_next  = 1'b1;
            div_next   = (eff_high != '0);
          end
          ST_RUN: begin
            if (idle) begin
              apply    = pending_reg;
              cnt_next = '0;
              div_next = 1'b0;
            end else if (wrap) begin
              apply     = pending_reg;
              cnt_next  = '0;
              tick_next = 1'b1;
              div_next  = (eff_high != '0);
            end else begin
              cnt_next = cnt_inc;
              div_next = (cnt_inc < high_reg);
            end
          end
          default: begin
            state_next = ST_STOP;
            cnt_next   = '0;
            div_next   = 1'b0;
          end
        endcase
      end

      period_next = apply ? shadow_period_reg : period_reg;
      high_next   = apply ? shadow_high_reg : high_reg;

      // A write landing on an apply edge is staged behind the one being consumed.
      shadow_period_next = wr_hit ? load_period : shadow_period_reg;
      shadow_high_next   = wr_hit ? load_high : shadow_high_reg;
      if (wr_hit) begin
        pending_next = 1'b1;
      end else if (apply) begin
        pending_next = 1'b0;
      end else begin
        pending_next = pending_reg;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg         <= ST_STOP;
        cnt_reg           <= '0;
        period_reg        <= DEF_P;
        high_reg          <= DEF_H;
        shadow_period_reg <= DEF_P;
        shadow_high_reg   <= DEF_H;
        pending_reg       <= 1'b0;
        div_reg           <= 1'b0;
        tick_reg          <= 1'b0;
      end else begin
        state_reg         <= state_next;
        cnt_reg           <= cnt_next;
        period_reg        <= period_next;
        high_reg          <= high_next;
        shadow_period_reg <= shadow_period_next;
        shadow_high_reg   <= shadow_high_next;
        pending_reg       <= pending_next;
        div_reg           <= div_next;
        tick_reg          <= tick_next;
      end
    end

    assign div_clk[gi] = div_reg;
    assign tick[gi]    = tick_reg;
  end

endmodule
